// File: rtl/simple_axi_slave_mem.sv
// simple_axi_slave_mem: AXI4 responder backed by a byte-writable array of
// DEPTH 64-bit words. Independent write (AW/W/B) and read (AR/R) state
// machines, INCR bursts, DECERR on out-of-range beats, SLVERR on other
// burst types (DECERR wins).
// Optional build macro SIMPLE_AXI_SLAVE_MEM_WAIT_EN inserts WAIT_CYCLES wait
// states ahead of every write beat (wready low) and read beat (rvalid low).
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid and ready are both high; the side asserting valid keeps it and
// its payload stable until that edge, and ready may change freely.
module simple_axi_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // write address
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic [7:0]  s_axi_awlen,
  // write data
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  // write response
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  // read address
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic [7:0]  s_axi_arlen,
  // read data
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  // state visibility
  output logic [1:0]  dbg_w_state,
  output logic        dbg_r_state
);

  localparam int          IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] RANGE_BYTES = 33'(DEPTH) * 33'd8;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  // Offset from BASE_ADDR; anything below BASE wraps to a huge offset.
  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return ({1'b0, off} < RANGE_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  logic [63:0] mem [DEPTH];

  // write channel state
  w_state_e    w_state_q, w_state_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [2:0]  w_size_q, w_size_d;
  logic [1:0]  w_burst_q, w_burst_d;
  logic [7:0]  w_cnt_q, w_cnt_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        mem_we;
  logic        w_wait_done;

  // read channel state
  r_state_e    r_state_q, r_state_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic [2:0]  r_size_q, r_size_d;
  logic [1:0]  r_burst_q, r_burst_d;
  logic [7:0]  r_cnt_q, r_cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        r_wait_done;

  // next-beat read lookup
  logic [31:0] rd_addr;
  logic [1:0]  rd_burst;
  logic [63:0] beat_data;
  logic [1:0]  beat_resp;

  assign dbg_w_state = w_state_q;
  assign dbg_r_state = r_state_q;
  assign s_axi_bresp = bresp_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;

  // write FSM: next state, handshakes, memory write enable, sticky response
  always_comb begin
    w_state_d     = w_state_q;
    w_addr_d      = w_addr_q;
    w_size_d      = w_size_q;
    w_burst_d     = w_burst_q;
    w_cnt_d       = w_cnt_q;
    bresp_d       = bresp_q;
    mem_we        = 1'b0;
    s_axi_awready = (w_state_q == W_IDLE);
    s_axi_wready  = (w_state_q == W_DATA) && w_wait_done;
    s_axi_bvalid  = (w_state_q == W_RESP);
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid) begin
          w_addr_d  = s_axi_awaddr;
          w_size_d  = s_axi_awsize;
          w_burst_d = s_axi_awburst;
          w_cnt_d   = s_axi_awlen;
          bresp_d   = RESP_OKAY;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && s_axi_wready) begin
          if (!in_range(w_addr_q)) begin
            bresp_d = RESP_DECERR;
          end else if (w_burst_q != BURST_INCR) begin
            if (bresp_q != RESP_DECERR) bresp_d = RESP_SLVERR;
          end else begin
            mem_we = 1'b1;
          end
          w_addr_d = w_addr_q + (32'd1 << w_size_q);
          // wlast is not trusted; the beat count alone ends the burst
          if (w_cnt_q == 8'd0) w_state_d = W_RESP;
          else                 w_cnt_d   = w_cnt_q - 8'd1;
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // write FSM registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= 32'd0;
      w_size_q  <= 3'd0;
      w_burst_q <= 2'd0;
      w_cnt_q   <= 8'd0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      bresp_q   <= bresp_d;
    end
  end

  // byte-lane memory write; contents survive reset
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (s_axi_wstrb[b]) mem[word_idx(w_addr_q)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // data/response for the beat about to be registered (first or next)
  always_comb begin
    rd_addr  = (r_state_q == R_IDLE) ? s_axi_araddr  : r_addr_q + (32'd1 << r_size_q);
    rd_burst = (r_state_q == R_IDLE) ? s_axi_arburst : r_burst_q;
    if (!in_range(rd_addr)) begin
      beat_data = 64'd0;
      beat_resp = RESP_DECERR;
    end else if (rd_burst != BURST_INCR) begin
      beat_data = 64'd0;
      beat_resp = RESP_SLVERR;
    end else begin
      beat_data = mem[word_idx(rd_addr)];
      beat_resp = RESP_OKAY;
    end
  end

  // read FSM: next state, handshakes, registered beat payload
  always_comb begin
    r_state_d     = r_state_q;
    r_addr_d      = r_addr_q;
    r_size_d      = r_size_q;
    r_burst_d     = r_burst_q;
    r_cnt_d       = r_cnt_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    s_axi_arready = (r_state_q == R_IDLE);
    s_axi_rvalid  = (r_state_q == R_DATA) && r_wait_done;
    s_axi_rlast   = s_axi_rvalid && (r_cnt_q == 8'd0);
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          r_addr_d  = s_axi_araddr;
          r_size_d  = s_axi_arsize;
          r_burst_d = s_axi_arburst;
          r_cnt_d   = s_axi_arlen;
          rdata_d   = beat_data;
          rresp_d   = beat_resp;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rvalid && s_axi_rready) begin
          if (r_cnt_q == 8'd0) begin
            r_state_d = R_IDLE;
          end else begin
            r_addr_d = rd_addr;
            r_cnt_d  = r_cnt_q - 8'd1;
            rdata_d  = beat_data;
            rresp_d  = beat_resp;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // read FSM registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= 32'd0;
      r_size_q  <= 3'd0;
      r_burst_q <= 2'd0;
      r_cnt_q   <= 8'd0;
      rdata_q   <= 64'd0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

`ifdef SIMPLE_AXI_SLAVE_MEM_WAIT_EN
  localparam logic [7:0] WAIT_LD = 8'(WAIT_CYCLES);

  logic [7:0] w_wait_q, w_wait_d;
  logic [7:0] r_wait_q, r_wait_d;

  assign w_wait_done = (w_wait_q == 8'd0);
  assign r_wait_done = (r_wait_q == 8'd0);

  // wait counters reload on address accept and after every beat handshake
  always_comb begin
    w_wait_d = w_wait_q;
    r_wait_d = r_wait_q;
    if ((s_axi_awvalid && s_axi_awready) || (s_axi_wvalid && s_axi_wready)) begin
      w_wait_d = WAIT_LD;
    end else if ((w_state_q == W_DATA) && !w_wait_done) begin
      w_wait_d = w_wait_q - 8'd1;
    end
    if ((s_axi_arvalid && s_axi_arready) || (s_axi_rvalid && s_axi_rready)) begin
      r_wait_d = WAIT_LD;
    end else if ((r_state_q == R_DATA) && !r_wait_done) begin
      r_wait_d = r_wait_q - 8'd1;
    end
  end

  // wait counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_wait_q <= 8'd0;
      r_wait_q <= 8'd0;
    end else begin
      w_wait_q <= w_wait_d;
      r_wait_q <= r_wait_d;
    end
  end
`else
  assign w_wait_done = 1'b1;
  assign r_wait_done = 1'b1;

  logic unused_wait_cfg;
  assign unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;

endmodule

// File: tb/tb_simple_axi_slave_mem.sv
// tb_simple_axi_slave_mem: directed scenarios against simple_axi_slave_mem
// with a word-array reference model; expected B and R payloads are queued
// when stimulus is driven and compared when the DUT presents them.
module tb_simple_axi_slave_mem;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;
  localparam int          BOUND = 200;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_awaddr = '0;
  logic [2:0]  s_axi_awsize = '0;
  logic [1:0]  s_axi_awburst = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [63:0] s_axi_wdata = '0;
  logic [7:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_araddr = '0;
  logic [2:0]  s_axi_arsize = '0;
  logic [1:0]  s_axi_arburst = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic [1:0]  dbg_w_state;
  logic        dbg_r_state;

  simple_axi_slave_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlen(s_axi_awlen),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlen(s_axi_arlen),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
  );

  // clock / watchdog
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_err    = 0;
  logic [63:0] exp_q[$];
  logic [1:0]  exp_resp_q[$];
  logic        exp_last_q[$];
  logic [1:0]  exp_b_q[$];
  logic [63:0] mdl [DEPTH];
  logic [63:0] wbeat_data [16];
  logic [7:0]  wbeat_strb [16];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic mdl_in(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + DEPTH * 8);
  endfunction

  function automatic int mdl_idx(input logic [31:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // drivers
  task automatic aw_drive(input logic [31:0] addr, input logic [2:0] size,
                          input logic [7:0] len, input logic [1:0] burst);
    int cyc = 0;
    s_axi_awvalid = 1'b1;
    s_axi_awaddr  = addr;
    s_axi_awsize  = size;
    s_axi_awlen   = len;
    s_axi_awburst = burst;
    while (!s_axi_awready && cyc < BOUND) begin tick(); cyc++; end
    check("awready", s_axi_awready, 1);
    tick();
    s_axi_awvalid = 1'b0;
  endtask

  // drives len+1 beats from wbeat_*, updates the model, queues the expected bresp
  task automatic w_drive(input logic [31:0] addr, input logic [2:0] size,
                         input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] a = addr;
    logic        dec = 1'b0;
    check("aw2w_lat", s_axi_wready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      int cyc = 0;
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = wbeat_data[i];
      s_axi_wstrb  = wbeat_strb[i];
      s_axi_wlast  = (i == int'(len));
      while (!s_axi_wready && cyc < BOUND) begin tick(); cyc++; end
      check("wready", s_axi_wready, 1);
      if (!mdl_in(a)) dec = 1'b1;
      else if (burst == 2'b01) begin
        for (int b = 0; b < 8; b++)
          if (wbeat_strb[i][b]) mdl[mdl_idx(a)][b*8 +: 8] = wbeat_data[i][b*8 +: 8];
      end
      a = a + (32'd1 << size);
      tick();
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    exp_b_q.push_back(dec ? 2'b11 : (burst != 2'b01) ? 2'b10 : 2'b00);
  endtask

  task automatic b_wait();
    int cyc = 0;
    check("b_lat", s_axi_bvalid, 1);
    s_axi_bready = 1'b1;
    while (!s_axi_bvalid && cyc < BOUND) begin tick(); cyc++; end
    check("bvalid", s_axi_bvalid, 1);
    if (exp_b_q.size() > 0) check("bresp", s_axi_bresp, exp_b_q.pop_front());
    else check("b_unexpected", s_axi_bvalid, 0);
    tick();
    s_axi_bready = 1'b0;
    check("b_done", s_axi_bvalid, 0);
  endtask

  task automatic ar_expect(input logic [31:0] addr, input logic [2:0] size,
                           input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      if (!mdl_in(a)) begin
        exp_q.push_back(64'd0); exp_resp_q.push_back(2'b11);
      end else if (burst != 2'b01) begin
        exp_q.push_back(64'd0); exp_resp_q.push_back(2'b10);
      end else begin
        exp_q.push_back(mdl[mdl_idx(a)]); exp_resp_q.push_back(2'b00);
      end
      exp_last_q.push_back(i == int'(len));
      a = a + (32'd1 << size);
    end
  endtask

  task automatic ar_drive(input logic [31:0] addr, input logic [2:0] size,
                          input logic [7:0] len, input logic [1:0] burst);
    int cyc = 0;
    ar_expect(addr, size, len, burst);
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = addr;
    s_axi_arsize  = size;
    s_axi_arlen   = len;
    s_axi_arburst = burst;
    while (!s_axi_arready && cyc < BOUND) begin tick(); cyc++; end
    check("arready", s_axi_arready, 1);
    tick();
    s_axi_arvalid = 1'b0;
  endtask

  // collects n beats; with toggle, rready runs 1,0,1,0 and stalled beats must hold
  task automatic r_collect(input int n, input bit toggle);
    int beat = 0;
    int cyc = 0;
    bit ph = 1'b0;
    while (beat < n && cyc < BOUND) begin
      s_axi_rready = toggle ? !ph : 1'b1;
      ph = !ph;
      if (s_axi_rvalid) begin
        if (exp_q.size() == 0) begin
          check("r_unexpected", s_axi_rvalid, 0);
        end else if (s_axi_rready) begin
          check("rdata", s_axi_rdata, exp_q.pop_front());
          check("rresp", s_axi_rresp, exp_resp_q.pop_front());
          check("rlast", s_axi_rlast, exp_last_q.pop_front());
          beat++;
        end else begin
          check("r_hold_data", s_axi_rdata, exp_q[0]);
          check("r_hold_last", s_axi_rlast, exp_last_q[0]);
        end
      end
      tick();
      cyc++;
    end
    s_axi_rready = 1'b0;
    check("r_beats", beat, n);
    check("r_end", s_axi_rvalid, 0);
  endtask

  // stimulus
  initial begin
    repeat (3) tick();
    i_rst = 1'b0;
    check("rst_awready", s_axi_awready, 1);
    check("rst_arready", s_axi_arready, 1);
    check("rst_wready", s_axi_wready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_rlast", s_axi_rlast, 0);
    check("rst_bresp", s_axi_bresp, 0);
    check("rst_rresp", s_axi_rresp, 0);
    check("rst_rdata", s_axi_rdata, 0);
    check("rst_wstate", dbg_w_state, 0);
    check("rst_rstate", dbg_r_state, 0);

    // dword write then read
    wbeat_data[0] = 64'h1122334455667788; wbeat_strb[0] = 8'hFF;
    aw_drive(BASE + 32'h10, 3'd3, 8'd0, 2'b01);
    w_drive(BASE + 32'h10, 3'd3, 8'd0, 2'b01);
    b_wait();
    ar_drive(BASE + 32'h10, 3'd3, 8'd0, 2'b01);
    r_collect(1, 1'b0);

    // single byte write into lane 3
    wbeat_data[0] = 64'h00000000_AB000000; wbeat_strb[0] = 8'h08;
    aw_drive(BASE + 32'h13, 3'd0, 8'd0, 2'b01);
    w_drive(BASE + 32'h13, 3'd0, 8'd0, 2'b01);
    b_wait();
    ar_drive(BASE + 32'h10, 3'd3, 8'd0, 2'b01);
    r_collect(1, 1'b0);

    // 4-beat INCR burst, read back with stalls
    for (int i = 0; i < 4; i++) begin wbeat_data[i] = 64'(i + 1); wbeat_strb[i] = 8'hFF; end
    aw_drive(BASE, 3'd3, 8'd3, 2'b01);
    w_drive(BASE, 3'd3, 8'd3, 2'b01);
    b_wait();
    ar_drive(BASE, 3'd3, 8'd3, 2'b01);
    r_collect(4, 1'b1);

    // decode error: one past the end, then a burst crossing the end
    wbeat_data[0] = 64'hDEAD_BEEF_0000_0001; wbeat_strb[0] = 8'hFF;
    aw_drive(BASE + DEPTH * 8, 3'd3, 8'd0, 2'b01);
    w_drive(BASE + DEPTH * 8, 3'd3, 8'd0, 2'b01);
    b_wait();
    ar_drive(BASE + DEPTH * 8, 3'd3, 8'd0, 2'b01);
    r_collect(1, 1'b0);
    ar_drive(BASE, 3'd3, 8'd0, 2'b01);
    r_collect(1, 1'b0);
    wbeat_data[0] = 64'hCAFE_F00D_1234_5678; wbeat_strb[0] = 8'hFF;
    aw_drive(BASE + (DEPTH - 1) * 8, 3'd3, 8'd0, 2'b01);
    w_drive(BASE + (DEPTH - 1) * 8, 3'd3, 8'd0, 2'b01);
    b_wait();
    ar_drive(BASE + (DEPTH - 1) * 8, 3'd3, 8'd1, 2'b01);
    r_collect(2, 1'b0);

    // WRAP burst: consumed, SLVERR, no memory change
    for (int i = 0; i < 2; i++) begin wbeat_data[i] = 64'h5A5A_5A5A_5A5A_5A5A; wbeat_strb[i] = 8'hFF; end
    aw_drive(BASE + 32'h10, 3'd3, 8'd1, 2'b10);
    w_drive(BASE + 32'h10, 3'd3, 8'd1, 2'b10);
    b_wait();
    ar_drive(BASE + 32'h10, 3'd3, 8'd0, 2'b01);
    r_collect(1, 1'b0);
    ar_drive(BASE + 32'h10, 3'd3, 8'd1, 2'b10);
    r_collect(2, 1'b0);

    // AW and AR in the same cycle to different words
    ar_expect(BASE + 32'h08, 3'd3, 8'd0, 2'b01);
    s_axi_awvalid = 1'b1; s_axi_awaddr = BASE + 32'h28; s_axi_awsize = 3'd3;
    s_axi_awlen = 8'd0; s_axi_awburst = 2'b01;
    s_axi_arvalid = 1'b1; s_axi_araddr = BASE + 32'h08; s_axi_arsize = 3'd3;
    s_axi_arlen = 8'd0; s_axi_arburst = 2'b01;
    check("cc_awready", s_axi_awready, 1);
    check("cc_arready", s_axi_arready, 1);
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_arvalid = 1'b0;
    check("cc_rvalid", s_axi_rvalid, 1);
    wbeat_data[0] = 64'h0F0E_0D0C_0B0A_0908; wbeat_strb[0] = 8'hFF;
    fork
      begin
        w_drive(BASE + 32'h28, 3'd3, 8'd0, 2'b01);
        b_wait();
      end
      r_collect(1, 1'b0);
    join
    ar_drive(BASE + 32'h28, 3'd3, 8'd0, 2'b01);
    r_collect(1, 1'b0);

    // reset during W_DATA after one beat of a 4-beat burst
    aw_drive(BASE + 32'h30, 3'd3, 8'd3, 2'b01);
    s_axi_wvalid = 1'b1; s_axi_wdata = 64'h7777_6666_5555_4444; s_axi_wstrb = 8'hFF;
    check("mid_wready", s_axi_wready, 1);
    mdl[6] = 64'h7777_6666_5555_4444;
    tick();
    s_axi_wvalid = 1'b0;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("mid_rst_awready", s_axi_awready, 1);
    check("mid_rst_wready", s_axi_wready, 0);
    check("mid_rst_bvalid", s_axi_bvalid, 0);
    ar_drive(BASE + 32'h30, 3'd3, 8'd0, 2'b01);
    r_collect(1, 1'b0);

    check("leftover_r", exp_q.size(), 0);
    check("leftover_b", exp_b_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
